innov_cov_diag: RTL

INNOV_COV_DIAG -- requirements
Module: innov_cov_diag

---
 rtl/innov_cov_diag_pkg.sv | 17 +
 rtl/innov_cov_diag_fp_adder.sv | 139 +++++++++++++
 rtl/innov_cov_diag.sv | 127 ++++++++++++
 3 files changed

// File: rtl/innov_cov_diag_pkg.sv
// Shared Kalman package: IEEE-754 double field layout and the innovation-covariance FSM states.
package innov_cov_diag_pkg;

  localparam int KALMAN_DBL_WIDTH = 64;
  localparam int EXP_W            = 11;
  localparam int FRAC_W           = 52;
  localparam int MANT_W           = FRAC_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [63:0]      QNAN    = 64'h7FF8_0000_0000_0000;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/innov_cov_diag_fp_adder.sv
// Shared IEEE-754 double adder, round-to-nearest-even, go/ready/finish handshake.
// Three cycles from an accepted go to the finish pulse carrying the sum.
module fp_adder
  import innov_cov_diag_pkg::*;
#(
  parameter int DBL_WIDTH = KALMAN_DBL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [DBL_WIDTH-1:0] a,
  input  logic [DBL_WIDTH-1:0] b,
  output logic                 ready,
  output logic                 finish,
  output logic [DBL_WIDTH-1:0] result
);

  localparam int ALN_W = MANT_W + 3;  // mantissa plus guard, round, sticky
  localparam int SUM_W = ALN_W + 1;   // plus carry-out

  logic                 busy;
  logic                 vld_p0, vld_p1;
  logic [DBL_WIDTH-1:0] a_p0, b_p0;
  logic                 sgn_p1;
  logic [EXP_W:0]       exp_p1;
  logic [SUM_W-1:0]     sum_p1;
  logic                 spec_p1;
  logic [DBL_WIDTH-1:0] spec_val_p1;

  function automatic logic [5:0] lzc(input logic [ALN_W-1:0] v);
    logic [5:0] n;
    n = 6'(ALN_W);
    for (int i = 0; i < ALN_W; i++)
      if (v[i]) n = 6'(ALN_W - 1 - i);
    return n;
  endfunction

  function automatic logic [ALN_W-1:0] align_sticky(input logic [ALN_W-1:0] v,
                                                    input logic [EXP_W:0]   d);
    logic [ALN_W-1:0] mask, sh;
    if (d >= (EXP_W+1)'(ALN_W)) return {{(ALN_W-1){1'b0}}, |v};
    mask = (ALN_W'(1) << d) - ALN_W'(1);
    sh   = v >> d;
    return {sh[ALN_W-1:1], sh[0] | (|(v & mask))};
  endfunction

  function automatic logic [DBL_WIDTH-1:0] round_pack(input logic             sgn,
                                                      input logic [EXP_W:0]   exp_in,
                                                      input logic [SUM_W-1:0] sum);
    logic [ALN_W-1:0]   s;
    logic [EXP_W+1:0]   e, ef;
    logic [5:0]         lz, sh;
    logic [MANT_W:0]    m;
    logic [FRAC_W-1:0]  frac;
    logic               up;
    if (sum[SUM_W-1]) begin
      s = {sum[SUM_W-1:2], sum[1] | sum[0]};
      e = {1'b0, exp_in} + 1'b1;
    end else begin
      // Left shift stops at the minimum exponent so tiny results become subnormal.
      lz = lzc(sum[ALN_W-1:0]);
      sh = ((EXP_W+1)'(lz) < exp_in) ? lz : 6'(exp_in - 1'b1);
      s  = sum[ALN_W-1:0] << sh;
      e  = {1'b0, exp_in} - (EXP_W+2)'(sh);
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[ALN_W-1:3]} + (MANT_W+1)'(up);
    if (m[MANT_W]) begin
      ef   = e + 1'b1;
      frac = m[MANT_W-1:1];
    end else begin
      ef   = m[MANT_W-1] ? e : '0;
      frac = m[FRAC_W-1:0];
    end
    if (ef >= (EXP_W+2)'(EXP_MAX)) return {sgn, EXP_MAX, {FRAC_W{1'b0}}};
    return {sgn, ef[EXP_W-1:0], frac};
  endfunction

  assign ready = ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      finish <= 1'b0;
    end else begin
      vld_p0 <= go & ready;
      vld_p1 <= vld_p0;
      finish <= vld_p1;
      if (go && ready) busy <= 1'b1;
      else if (finish) busy <= 1'b0;
    end
  end

  // Stage p0 -> p1: order by magnitude, align the smaller operand, add or subtract
  logic [DBL_WIDTH-1:0] x, y;
  logic [EXP_W:0]       ex_e, ey_e, d;
  logic [MANT_W-1:0]    mx, my;
  logic [ALN_W-1:0]     mya;
  logic                 sub;
  logic [SUM_W-1:0]     sum_c;
  logic                 sgn_c, spec_c;
  logic [DBL_WIDTH-1:0] spec_val_c;

  always_comb begin
    x    = (a_p0[DBL_WIDTH-2:0] >= b_p0[DBL_WIDTH-2:0]) ? a_p0 : b_p0;
    y    = (a_p0[DBL_WIDTH-2:0] >= b_p0[DBL_WIDTH-2:0]) ? b_p0 : a_p0;
    ex_e = (x[DBL_WIDTH-2:FRAC_W] == '0) ? (EXP_W+1)'(1) : {1'b0, x[DBL_WIDTH-2:FRAC_W]};
    ey_e = (y[DBL_WIDTH-2:FRAC_W] == '0) ? (EXP_W+1)'(1) : {1'b0, y[DBL_WIDTH-2:FRAC_W]};
    mx   = {x[DBL_WIDTH-2:FRAC_W] != '0, x[FRAC_W-1:0]};
    my   = {y[DBL_WIDTH-2:FRAC_W] != '0, y[FRAC_W-1:0]};
    d    = ex_e - ey_e;
    mya  = align_sticky({my, 3'b000}, d);
    sub  = x[DBL_WIDTH-1] ^ y[DBL_WIDTH-1];
    sum_c = sub ? ({1'b0, mx, 3'b000} - {1'b0, mya}) : ({1'b0, mx, 3'b000} + {1'b0, mya});
    sgn_c = (sub && sum_c == '0) ? 1'b0 : x[DBL_WIDTH-1];
    spec_c = (x[DBL_WIDTH-2:FRAC_W] == EXP_MAX);
    spec_val_c = ((x[FRAC_W-1:0] != '0) || (y[DBL_WIDTH-2:FRAC_W] == EXP_MAX && sub))
                 ? DBL_WIDTH'(QNAN) : x;
  end

  always_ff @(posedge clk) begin
    if (go && ready) begin
      a_p0 <= a;
      b_p0 <= b;
    end
    if (vld_p0) begin
      sgn_p1      <= sgn_c;
      exp_p1      <= ex_e;
      sum_p1      <= sum_c;
      spec_p1     <= spec_c;
      spec_val_p1 <= spec_val_c;
    end
    // Stage p1 -> result: normalise, round, pack
    if (vld_p1) result <= spec_p1 ? spec_val_p1 : round_pack(sgn_p1, exp_p1, sum_p1);
  end

endmodule

// File: rtl/innov_cov_diag.sv
// Innovation-covariance diagonal S_kk = P_kk + R_kk, one shared double adder behind an input FIFO.
// Optional macro INNOV_COV_CNT_EN adds the 16-bit completed-vector counter vec_cnt.
module innov_cov_diag
  import innov_cov_diag_pkg::*;
#(
  parameter int DBL_WIDTH  = KALMAN_DBL_WIDTH,
  parameter int N_DIAG     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DBL_WIDTH-1:0]        p_in,
  input  logic                        p_valid,
  input  logic [N_DIAG*DBL_WIDTH-1:0] r_diag,
  output logic [N_DIAG*DBL_WIDTH-1:0] s_diag,
  output logic                        s_valid,
  output logic [$clog2(N_DIAG)-1:0]   elem_idx,
  output logic                        overflow
`ifdef INNOV_COV_CNT_EN
  ,
  output logic [15:0]                 vec_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(N_DIAG);

  logic [DBL_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_empty, fifo_full, push, pop;

  state_t               state;
  logic                 go;
  logic [DBL_WIDTH-1:0] a_q, b_q;
  logic                 add_ready, add_finish;
  logic [DBL_WIDTH-1:0] add_result;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign pop        = (state == S_IDLE) && !fifo_empty && add_ready;
  // A full FIFO still takes a strobe when the head leaves in the same cycle.
  assign push       = p_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      if (p_valid && !push) overflow <= 1'b1;
    end
  end

  // Input buffer -> operand registers: r_diag is captured here, at the pop
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= p_in;
    if (pop) begin
      a_q <= fifo_mem[rd_ptr];
      b_q <= r_diag[elem_idx*DBL_WIDTH +: DBL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      go       <= 1'b0;
      s_valid  <= 1'b0;
      elem_idx <= '0;
      s_diag   <= '0;
    end else begin
      go      <= 1'b0;
      s_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            go    <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (add_finish) begin
            s_diag[elem_idx*DBL_WIDTH +: DBL_WIDTH] <= add_result;
            if (elem_idx == IDX_W'(N_DIAG - 1)) begin
              elem_idx <= '0;
              s_valid  <= 1'b1;
            end else begin
              elem_idx <= elem_idx + 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INNOV_COV_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)          vec_cnt <= '0;
    else if (s_valid) vec_cnt <= vec_cnt + 1'b1;
  end
`endif

  fp_adder #(
    .DBL_WIDTH (DBL_WIDTH)
  ) u_fp_adder (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .a      (a_q),
    .b      (b_q),
    .ready  (add_ready),
    .finish (add_finish),
    .result (add_result)
  );

endmodule
